// File: rtl/shift_pkg.sv
// Shared encodings for the shift-register controller: mux select codes
// driven to every register bit and the two FSM states.
package shift_pkg;

  typedef enum logic [1:0] {
    SEL_HOLD  = 2'b00,
    SEL_RIGHT = 2'b01,
    SEL_LEFT  = 2'b10,
    SEL_LOAD  = 2'b11
  } sel_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/shift_ctrl_if.sv
// Operator inputs and mux-control outputs of the shift controller.
// master: the side driving buttons/switches; slave: the controller.
interface shift_ctrl_if;

  logic       btn_load;
  logic       btn_left;
  logic       btn_right;
  logic       run;
  logic       dir;
  logic [1:0] sel;
  logic [7:0] op_cnt;
  logic       running;

  modport master (
    output btn_load, btn_left, btn_right, run, dir,
    input  sel, op_cnt, running
  );

  modport slave (
    input  btn_load, btn_left, btn_right, run, dir,
    output sel, op_cnt, running
  );

endinterface

// File: rtl/btn_debounce.sv
// Raw pushbutton conditioning: 2-flop synchronizer, counting debouncer and
// rising-edge detector. pulse is high for one cycle, registered, in the
// same cycle the debounced level rises; holding the button gives no repeats.
module btn_debounce
  import shift_pkg::*;
#(
  parameter logic [15:0] DB_CNT = 16'd50000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic        sync_meta_r;
  logic        sync_r;
  logic        level_r;
  logic [15:0] cnt_r;
  logic        pulse_r;

  // Two-flop synchronizer for the asynchronous button input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_meta_r <= 1'b0;
      sync_r      <= 1'b0;
    end else begin
      sync_meta_r <= btn;
      sync_r      <= sync_meta_r;
    end
  end

  // Flip the debounced level after DB_CNT consecutive samples that differ
  // from it; any sample matching the current level restarts the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      level_r <= 1'b0;
      cnt_r   <= 16'd0;
      pulse_r <= 1'b0;
    end else begin
      pulse_r <= 1'b0;
      if (sync_r == level_r) begin
        cnt_r <= 16'd0;
      end else if (cnt_r == (DB_CNT - 16'd1)) begin
        level_r <= sync_r;
        cnt_r   <= 16'd0;
        pulse_r <= sync_r;
      end else begin
        cnt_r <= cnt_r + 16'd1;
      end
    end
  end

  assign pulse = pulse_r;

endmodule

// File: rtl/shift_ctrl.sv
// Shift-register controller: conditions three buttons and the run/dir
// switches, runs an IDLE/RUN FSM with a periodic shift tick, arbitrates
// requests (load > left > right > tick) into a one-cycle registered sel
// command, and counts issued commands.
module shift_ctrl
  import shift_pkg::*;
#(
  parameter logic [15:0] DB_CNT   = 16'd50000,
  parameter logic [23:0] TICK_DIV = 24'd5000000
) (
  input logic        clk,
  input logic        rst,
  shift_ctrl_if.slave bus
);

  localparam logic [23:0] TICK_MAX = TICK_DIV - 24'd1;

  logic        load_pulse_s;
  logic        left_pulse_s;
  logic        right_pulse_s;
  logic        run_meta_r;
  logic        run_sync_r;
  logic        dir_meta_r;
  logic        dir_sync_r;
  state_e      state_r;
  state_e      state_nxt_s;
  logic [23:0] tick_cnt_r;
  logic        tick_s;
  sel_e        sel_r;
  sel_e        sel_nxt_s;
  logic [7:0]  op_cnt_r;
  logic        running_r;

  btn_debounce #(.DB_CNT(DB_CNT)) u_db_load (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_load),
    .pulse (load_pulse_s)
  );

  btn_debounce #(.DB_CNT(DB_CNT)) u_db_left (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_left),
    .pulse (left_pulse_s)
  );

  btn_debounce #(.DB_CNT(DB_CNT)) u_db_right (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_right),
    .pulse (right_pulse_s)
  );

  // Synchronize the run and dir switches (levels, no debounce needed).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_meta_r <= 1'b0;
      run_sync_r <= 1'b0;
      dir_meta_r <= 1'b0;
      dir_sync_r <= 1'b0;
    end else begin
      run_meta_r <= bus.run;
      run_sync_r <= run_meta_r;
      dir_meta_r <= bus.dir;
      dir_sync_r <= dir_meta_r;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: follow the synchronized run switch.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (run_sync_r) state_nxt_s = ST_RUN;
        else            state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (!run_sync_r) state_nxt_s = ST_IDLE;
        else             state_nxt_s = ST_RUN;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Tick counter: counts only while staying in RUN, cleared in IDLE and on
  // entry, so the first tick lands TICK_DIV cycles after entering RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tick_cnt_r <= 24'd0;
    end else if ((state_r == ST_RUN) && (state_nxt_s == ST_RUN)) begin
      if (tick_cnt_r == TICK_MAX) tick_cnt_r <= 24'd0;
      else                        tick_cnt_r <= tick_cnt_r + 24'd1;
    end else begin
      tick_cnt_r <= 24'd0;
    end
  end

  // No tick on the cycle the FSM is leaving RUN.
  assign tick_s = (state_r == ST_RUN) && (state_nxt_s == ST_RUN) &&
                  (tick_cnt_r == TICK_MAX);

  // Fixed-priority arbitration; losing requests are dropped, not queued.
  always_comb begin
    sel_nxt_s = SEL_HOLD;
    if (load_pulse_s) begin
      sel_nxt_s = SEL_LOAD;
    end else if (left_pulse_s) begin
      sel_nxt_s = SEL_LEFT;
    end else if (right_pulse_s) begin
      sel_nxt_s = SEL_RIGHT;
    end else if (tick_s) begin
      if (dir_sync_r) sel_nxt_s = SEL_LEFT;
      else            sel_nxt_s = SEL_RIGHT;
    end else begin
      sel_nxt_s = SEL_HOLD;
    end
  end

  // Registered command, command counter and RUN indicator.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel_r     <= SEL_HOLD;
      op_cnt_r  <= 8'h00;
      running_r <= 1'b0;
    end else begin
      sel_r     <= sel_nxt_s;
      running_r <= (state_nxt_s == ST_RUN);
      if (sel_r != SEL_HOLD) op_cnt_r <= op_cnt_r + 8'h01;
      else                   op_cnt_r <= op_cnt_r;
    end
  end

  assign bus.sel     = sel_r;
  assign bus.op_cnt  = op_cnt_r;
  assign bus.running = running_r;

endmodule

// File: tb/tb_shift_ctrl.sv
// Directed bench for shift_ctrl with DB_CNT=4, TICK_DIV=8.
// Latency from a button change to sel: 2 sync + 4 debounce + 1 sel = sample
// index 6 when the input is applied before the first observed edge.
module tb_shift_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   passed;

  shift_ctrl_if bus ();

  shift_ctrl #(.DB_CNT(16'd4), .TICK_DIV(24'd8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.btn_load = 1'b0; bus.btn_left = 1'b0; bus.btn_right = 1'b0;
    bus.run = 1'b0; bus.dir = 1'b0;
    idle_cycles(3);
    total++; if (bus.sel !== 2'b00) $display("FAIL reset_sel: got %b want 00", bus.sel); else passed++;
    total++; if (bus.op_cnt !== 8'h00) $display("FAIL reset_op_cnt: got %h want 00", bus.op_cnt); else passed++;
    total++; if (bus.running !== 1'b0) $display("FAIL reset_running: got %b want 0", bus.running); else passed++;
    @(negedge clk); rst = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_left_hold;
    int nz, bad, first, rises;
    logic [1:0] prev;
    nz = 0; bad = 0; first = -1; rises = 0; prev = 2'b00;
    bus.btn_left = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.sel !== 2'b00) begin
        nz++;
        if (first < 0) first = i;
        if (bus.sel !== 2'b10) bad++;
        if (prev === 2'b00) rises++;
      end
      prev = bus.sel;
    end
    total++; if (rises != 1) $display("FAIL left_pulses: got %0d want 1", rises); else passed++;
    total++; if (nz != 1) $display("FAIL left_width: got %0d cycles want 1", nz); else passed++;
    total++; if (bad != 0) $display("FAIL left_code: got %0d non-10 cycles want 0", bad); else passed++;
    total++; if (first != 6) $display("FAIL left_latency: got %0d want 6", first); else passed++;
    total++; if (bus.op_cnt !== 8'h01) $display("FAIL left_op_cnt: got %h want 01", bus.op_cnt); else passed++;
    bus.btn_left = 1'b0;
    idle_cycles(10);
  endtask

  task automatic test_bounce;
    logic [7:0] pat;
    int nz, bad, first;
    pat = 8'b00110011;
    nz = 0; bad = 0; first = -1;
    for (int i = 0; i < 28; i++) begin
      if (i < 8) bus.btn_right = pat[i];
      else       bus.btn_right = 1'b1;
      @(posedge clk); #1;
      if (bus.sel !== 2'b00) begin
        nz++;
        if (first < 0) first = i;
        if (bus.sel !== 2'b01) bad++;
      end
    end
    total++; if (nz != 1) $display("FAIL bounce_pulses: got %0d want 1", nz); else passed++;
    total++; if (bad != 0) $display("FAIL bounce_code: got %0d bad cycles want 0", bad); else passed++;
    total++; if (first != 14) $display("FAIL bounce_latency: got %0d want 14", first); else passed++;
    total++; if (bus.op_cnt !== 8'h02) $display("FAIL bounce_op_cnt: got %h want 02", bus.op_cnt); else passed++;
    bus.btn_right = 1'b0;
    idle_cycles(10);
  endtask

  task automatic test_run;
    int nz, bad, first, prev, gap_bad;
    nz = 0; bad = 0; first = -1; prev = -1; gap_bad = 0;
    bus.dir = 1'b0;
    bus.run = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.sel !== 2'b00) begin
        nz++;
        if (first < 0) first = i;
        if (bus.sel !== 2'b01) bad++;
        if ((prev >= 0) && (i - prev != 8)) gap_bad++;
        prev = i;
      end
    end
    total++; if (bus.running !== 1'b1) $display("FAIL run_running: got %b want 1", bus.running); else passed++;
    total++; if (nz != 4) $display("FAIL run_right_pulses: got %0d want 4", nz); else passed++;
    total++; if (bad != 0) $display("FAIL run_right_code: got %0d bad want 0", bad); else passed++;
    total++; if (gap_bad != 0) $display("FAIL run_right_spacing: got %0d bad gaps want 0", gap_bad); else passed++;
    total++; if (first != 10) $display("FAIL run_first_tick: got %0d want 10", first); else passed++;
    nz = 0; bad = 0; first = -1; prev = -1; gap_bad = 0;
    bus.dir = 1'b1;
    for (int j = 0; j < 24; j++) begin
      @(posedge clk); #1;
      if (bus.sel !== 2'b00) begin
        nz++;
        if (first < 0) first = j;
        if (bus.sel !== 2'b10) bad++;
        if ((prev >= 0) && (j - prev != 8)) gap_bad++;
        prev = j;
      end
    end
    total++; if (nz != 3) $display("FAIL run_left_pulses: got %0d want 3", nz); else passed++;
    total++; if (bad != 0) $display("FAIL run_left_code: got %0d bad want 0", bad); else passed++;
    total++; if (first != 2) $display("FAIL run_left_first: got %0d want 2", first); else passed++;
    total++; if (gap_bad != 0) $display("FAIL run_left_spacing: got %0d bad gaps want 0", gap_bad); else passed++;
    bus.run = 1'b0;
    bus.dir = 1'b0;
    idle_cycles(8);
    total++; if (bus.running !== 1'b0) $display("FAIL run_stop: got %b want 0", bus.running); else passed++;
    total++; if (bus.op_cnt !== 8'h09) $display("FAIL run_op_cnt: got %h want 09", bus.op_cnt); else passed++;
  endtask

  task automatic test_collide;
    int nz, bad;
    nz = 0; bad = 0;
    bus.btn_load = 1'b1;
    bus.btn_left = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.sel !== 2'b00) begin
        nz++;
        if (bus.sel !== 2'b11) bad++;
      end
    end
    total++; if (nz != 1) $display("FAIL collide_pulses: got %0d want 1", nz); else passed++;
    total++; if (bad != 0) $display("FAIL collide_code: got %0d non-11 want 0", bad); else passed++;
    total++; if (bus.op_cnt !== 8'h0a) $display("FAIL collide_op_cnt: got %h want 0a", bus.op_cnt); else passed++;
    bus.btn_load = 1'b0;
    bus.btn_left = 1'b0;
    idle_cycles(10);
  endtask

  task automatic test_reset_mid;
    int seen, nz, bad, first;
    seen = 0; nz = 0; bad = 0; first = -1;
    bus.run = 1'b1;
    idle_cycles(5);
    bus.btn_load = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.sel === 2'b11) begin
        seen = 1;
        break;
      end
    end
    total++; if (seen != 1) $display("FAIL mid_load_seen: got %0d want 1", seen); else passed++;
    total++; if (bus.running !== 1'b1) $display("FAIL mid_running_before: got %b want 1", bus.running); else passed++;
    #2 rst = 1'b0;
    #1;
    total++; if (bus.sel !== 2'b00) $display("FAIL mid_rst_sel: got %b want 00", bus.sel); else passed++;
    total++; if (bus.op_cnt !== 8'h00) $display("FAIL mid_rst_op_cnt: got %h want 00", bus.op_cnt); else passed++;
    total++; if (bus.running !== 1'b0) $display("FAIL mid_rst_running: got %b want 0", bus.running); else passed++;
    bus.run = 1'b0;
    idle_cycles(3);
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.sel !== 2'b00) begin
        nz++;
        if (first < 0) first = i;
        if (bus.sel !== 2'b11) bad++;
      end
    end
    total++; if (nz != 1) $display("FAIL held_pulses: got %0d want 1", nz); else passed++;
    total++; if ((bad != 0) || (first != 6)) $display("FAIL held_timing: got first %0d bad %0d want 6 0", first, bad); else passed++;
    total++; if (bus.op_cnt !== 8'h01) $display("FAIL held_op_cnt: got %h want 01", bus.op_cnt); else passed++;
    bus.btn_load = 1'b0;
    idle_cycles(10);
  endtask

  task automatic test_wrap;
    int cmds;
    logic [7:0] cnt_at_last;
    cmds = 0; cnt_at_last = 8'h00;
    @(negedge clk); rst = 1'b0;
    #1;
    total++; if (bus.op_cnt !== 8'h00) $display("FAIL wrap_start: got %h want 00", bus.op_cnt); else passed++;
    @(negedge clk); rst = 1'b1;
    bus.dir = 1'b0;
    bus.run = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (bus.sel !== 2'b00) cmds++;
      if (cmds == 256) begin
        cnt_at_last = bus.op_cnt;
        break;
      end
    end
    bus.run = 1'b0;
    total++; if (cmds != 256) $display("FAIL wrap_cmds: got %0d want 256", cmds); else passed++;
    total++; if (cnt_at_last !== 8'hff) $display("FAIL wrap_before: got %h want ff", cnt_at_last); else passed++;
    @(posedge clk); #1;
    total++; if (bus.op_cnt !== 8'h00) $display("FAIL wrap_after: got %h want 00", bus.op_cnt); else passed++;
    idle_cycles(10);
    total++; if ((bus.op_cnt !== 8'h00) || (bus.running !== 1'b0))
      $display("FAIL wrap_settle: got op_cnt %h running %b want 00 0", bus.op_cnt, bus.running);
    else passed++;
  endtask

  initial begin
    total = 0;
    passed = 0;
    test_reset();
    test_left_hold();
    test_bounce();
    test_run();
    test_collide();
    test_reset_mid();
    test_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/shift_ctrl.md
SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 The module SHALL have one clock and an asynchronous, active-low reset (clk, rst); no other clock or reset SHALL exist.
REQ-002 Parameters (name, default, meaning), one per line:
  DB_CNT  16'd50000  consecutive stable samples a button needs to count as debounced
  TICK_DIV  24'd5000000  clk cycles between automatic shifts in run mode
REQ-003 Ports (name  direction  width  meaning), one per line:
  clk  input  1  rising-edge system clock
  rst  input  1  asynchronous reset, active low
  btn_load  input  1  raw pushbutton: request parallel load
  btn_left  input  1  raw pushbutton: request one left shift
  btn_right  input  1  raw pushbutton: request one right shift
  run  input  1  raw switch: 1 = automatic shifting
  dir  input  1  raw switch: run-mode direction, 0 = right, 1 = left
  sel  output  2  4:1 mux select driven to every register-bit mux
  op_cnt  output  8  count of non-hold commands issued
  running  output  1  high while the FSM is in RUN

Function
REQ-004 sel encoding SHALL be: 2'b00 hold, 2'b01 shift right, 2'b10 shift left, 2'b11 parallel load.
REQ-005 sel SHALL be 2'b00 on every cycle except a command cycle, and a command SHALL last exactly one clk cycle.
REQ-006 Each button SHALL pass through a 2-flop synchronizer, then a debouncer that changes its debounced level only after DB_CNT consecutive identical synchronized samples.
REQ-007 A rising edge of a debounced button SHALL produce a one-cycle pulse; holding the button SHALL NOT generate repeat pulses.
REQ-008 run and dir SHALL be 2-flop synchronized but not debounced.
REQ-009 The FSM SHALL have two states: IDLE and RUN.
REQ-010 IDLE SHALL go to RUN when synchronized run = 1, and RUN SHALL go to IDLE when synchronized run = 0.
REQ-011 In RUN, a tick counter SHALL count 0..TICK_DIV-1 and wrap; at wrap it SHALL raise a tick.
REQ-012 The tick counter SHALL clear to 0 in IDLE and on entry to RUN, so the first tick occurs TICK_DIV cycles after entry.
REQ-013 A tick SHALL request a shift in the direction given by synchronized dir, sampled on the tick cycle.
REQ-014 When several requests are present in one cycle, priority SHALL be load > left > right > tick; lower-priority requests in that cycle SHALL be discarded, not queued.
REQ-015 sel SHALL be registered, with a latency of exactly 1 clk from the request pulse or tick to sel being non-zero.
REQ-016 op_cnt SHALL increment by 1 in the cycle after every non-hold sel and SHALL wrap 8'hFF -> 8'h00.
REQ-017 Button commands SHALL be accepted in both IDLE and RUN.
REQ-018 running SHALL be a registered decode of state == RUN.

Reset
REQ-019 While rst = 0, sel SHALL be 2'b00, op_cnt 8'h00, running 0, state IDLE, all counters 0, and all synchronizer and debounce levels 0.
REQ-020 An assertion of rst mid-command SHALL force sel to 2'b00 immediately (asynchronously), and no pending request SHALL survive the reset.
REQ-021 After rst deasserts, a button already held SHALL produce one pulse once DB_CNT stable samples have elapsed.

Structure
REQ-022 A shared package shift_pkg SHALL hold the sel encodings (SEL_HOLD, SEL_RIGHT, SEL_LEFT, SEL_LOAD) and the FSM state encodings (ST_IDLE, ST_RUN).
REQ-023 The synchronizer plus debouncer plus edge detector SHALL be one sub-module, btn_debounce, instantiated three times.
REQ-024 The FSM, tick counter, arbitration and op_cnt SHALL reside in shift_ctrl.

Verification (DB_CNT=4, TICK_DIV=8)
REQ-025 The bench SHALL cover: btn_left held 20 cycles -> exactly one sel=2'b10 pulse, 1 cycle wide, op_cnt 0->1.
REQ-026 The bench SHALL cover: btn_right bouncing 1,0,1,0 with 2-cycle periods, then stable 1 -> one sel=2'b01 pulse only after the stable run.
REQ-027 The bench SHALL cover: run=1, dir=0 for 40 cycles -> running=1 and sel=2'b01 pulses spaced exactly 8 cycles apart; dir=1 -> subsequent pulses are 2'b10.
REQ-028 The bench SHALL cover: btn_load and btn_left debounced pulses in the same cycle -> a single sel=2'b11 and op_cnt +1 only.
REQ-029 The bench SHALL cover: 256 commands from op_cnt=8'h00 -> op_cnt wraps back to 8'h00.
REQ-030 The bench SHALL cover: rst=0 asserted in the cycle sel=2'b11 -> sel=2'b00, op_cnt=0, running=0 before the next clk edge.
